l1_icache: RTL and testbench

- Direct-mapped, read-only L1 instruction cache between the fetch stage and the instruction-side port of the L1-to-L2 request arbiter.
- Hits return the word combinationally in the same cycle as the request.
- A miss fills the whole line, one word at a time, through the downstream request/fulfil handshake, then serves the request.
- A flush input invalidates all lines (fence.i).

---
 rtl/l1_icache_if.sv | 23 ++
 rtl/l1_icache.sv | 144 ++++++++++++++
 tb/tb_l1_icache.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/l1_icache_if.sv
// rtl/l1_icache_if.sv - word request/fulfil handshake shared by the fetch side and the L2 side
interface l1_icache_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic [XLEN-1:0] req_address;
  logic            req_fulfilled;
  logic [XLEN-1:0] req_loaded_word;

  modport master (
    output req_valid,
    output req_address,
    input  req_fulfilled,
    input  req_loaded_word
  );

  modport slave (
    input  req_valid,
    input  req_address,
    output req_fulfilled,
    output req_loaded_word
  );
endinterface

// File: rtl/l1_icache.sv
// rtl/l1_icache.sv - direct-mapped read-only L1 instruction cache with whole-line fill and flush
module l1_icache #(
  parameter int XLEN           = 32,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  l1_icache_if.slave  cpu,
  l1_icache_if.master mem
);
  localparam int OFF    = $clog2(WORDS_PER_LINE);
  localparam int IDX    = $clog2(NUM_LINES);
  localparam int LINE_W = XLEN - OFF - 2;
  localparam int TAG_W  = LINE_W - IDX;

  typedef enum logic {
    ST_IDLE,
    ST_FILL
  } state_t;

  state_t               state_q, state_d;
  logic [OFF-1:0]       fill_cnt_q, fill_cnt_d;
  logic [LINE_W-1:0]    line_q, line_d;
  logic                 gap_q, gap_d;
  logic                 flush_pending_q, flush_pending_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [XLEN-1:0]      data_q [NUM_LINES][WORDS_PER_LINE];

  logic [LINE_W-1:0] req_line;
  logic [IDX-1:0]    req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [OFF-1:0]    req_off;
  logic [IDX-1:0]    fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              last_word;
  logic              data_we;
  logic              tag_we;
  logic              unused_addr_bits;

  assign req_line  = cpu.req_address[XLEN-1:OFF+2];
  assign req_off   = cpu.req_address[OFF+1:2];
  assign req_idx   = req_line[IDX-1:0];
  assign req_tag   = req_line[LINE_W-1:IDX];
  // The fill works from the latched line so a dropped request cannot redirect it.
  assign fill_idx  = line_q[IDX-1:0];
  assign fill_tag  = line_q[LINE_W-1:IDX];
  assign last_word = (fill_cnt_q == OFF'(WORDS_PER_LINE - 1));
  assign unused_addr_bits = ^cpu.req_address[1:0];

  assign hit = (state_q == ST_IDLE) && cpu.req_valid && valid_q[req_idx]
               && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d             = state_q;
    fill_cnt_d          = fill_cnt_q;
    line_d              = line_q;
    gap_d               = 1'b0;
    flush_pending_d     = flush_pending_q;
    valid_d             = valid_q;
    data_we             = 1'b0;
    tag_we              = 1'b0;
    cpu.req_fulfilled   = 1'b0;
    cpu.req_loaded_word = data_q[req_idx][req_off];
    mem.req_valid       = 1'b0;
    mem.req_address     = '0;

    case (state_q)
      ST_IDLE: begin
        flush_pending_d = 1'b0;
        if (hit) begin
          cpu.req_fulfilled = 1'b1;
        end else if (cpu.req_valid) begin
          line_d           = req_line;
          fill_cnt_d       = '0;
          valid_d[req_idx] = 1'b0;
          state_d          = ST_FILL;
        end
        // A fill starting now reads memory after the flush, so no pending mark is needed.
        if (flush) begin
          valid_d = '0;
        end
      end

      ST_FILL: begin
        mem.req_valid   = !gap_q;
        mem.req_address = {line_q, fill_cnt_q, 2'b00};
        if (flush) begin
          flush_pending_d = 1'b1;
        end
        if (mem.req_fulfilled && !gap_q) begin
          data_we = 1'b1;
          if (last_word) begin
            tag_we          = 1'b1;
            state_d         = ST_IDLE;
            fill_cnt_d      = '0;
            flush_pending_d = 1'b0;
            if (flush_pending_q || flush) begin
              valid_d = '0;
            end else begin
              valid_d[fill_idx] = 1'b1;
            end
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
            gap_d      = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      fill_cnt_q      <= '0;
      line_q          <= '0;
      gap_q           <= 1'b0;
      flush_pending_q <= 1'b0;
      valid_q         <= '0;
    end else begin
      state_q         <= state_d;
      fill_cnt_q      <= fill_cnt_d;
      line_q          <= line_d;
      gap_q           <= gap_d;
      flush_pending_q <= flush_pending_d;
      valid_q         <= valid_d;
    end
  end

  // Tag and data storage are deliberately left unreset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!reset && data_we) begin
      data_q[fill_idx][fill_cnt_q] <= mem.req_loaded_word;
    end
    if (!reset && tag_we) begin
      tag_q[fill_idx] <= fill_tag;
    end
  end
endmodule

// File: tb/tb_l1_icache.sv
// tb/tb_l1_icache.sv - randomized self-checking bench for l1_icache against a line-presence model
module tb_l1_icache;
  localparam int W  = 4;
  localparam int NL = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  l1_icache_if #(.XLEN(32)) cpu_if();
  l1_icache_if #(.XLEN(32)) mem_if();

  l1_icache #(
    .XLEN(32),
    .NUM_LINES(NL),
    .WORDS_PER_LINE(W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .cpu(cpu_if),
    .mem(mem_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit          model_valid [NL];
  logic [31:0] model_line  [NL];

  logic [31:0] req_log [$];
  bit          busy;
  bit          stale;
  bit          just_done;
  int          wait_cnt;
  logic [31:0] cur_addr;
  int          fixed_delay;
  logic [31:0] salt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NL; i++) model_valid[i] = 1'b0;
  endtask

  // Downstream memory: returns address ^ salt after a chosen number of extra cycles.
  initial begin
    busy = 1'b0;
    stale = 1'b0;
    just_done = 1'b0;
    wait_cnt = 0;
    cur_addr = '0;
    mem_if.req_fulfilled   = 1'b0;
    mem_if.req_loaded_word = '0;
    forever begin
      @(negedge clk);
      mem_if.req_fulfilled = 1'b0;
      if (reset && busy) stale = 1'b1;
      if (just_done && !reset) check_eq("mem_gap", 32'(mem_if.req_valid), 32'd0);
      just_done = 1'b0;
      if (!busy && !reset && mem_if.req_valid === 1'b1) begin
        busy     = 1'b1;
        cur_addr = mem_if.req_address;
        req_log.push_back(cur_addr);
        wait_cnt = (fixed_delay < 0) ? int'($urandom_range(0, 7)) : fixed_delay;
      end else if (busy && !stale) begin
        check_eq("mem_valid_held", 32'(mem_if.req_valid), 32'd1);
        check_eq("mem_addr_held", mem_if.req_address, cur_addr);
      end
      if (busy) begin
        if (wait_cnt == 0) begin
          mem_if.req_fulfilled   = 1'b1;
          mem_if.req_loaded_word = cur_addr ^ salt;
          just_done = !stale;
          busy  = 1'b0;
          stale = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  task automatic do_flush();
    @(negedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    #1 flush = 1'b0;
    model_clear();
  endtask

  task automatic fetch(input logic [31:0] addr, input int flush_at);
    int          start, cycles, exp_n, idx, got_n;
    logic [31:0] line;
    bit          hit, done, flushed;
    line  = addr >> 4;
    idx   = int'(line % NL);
    hit   = model_valid[idx] && (model_line[idx] == line);
    exp_n = hit ? 0 : ((flush_at > 0) ? 2 * W : W);
    start = req_log.size();
    @(negedge clk);
    cpu_if.req_valid   = 1'b1;
    cpu_if.req_address = addr;
    done = 1'b0;
    flushed = 1'b0;
    cycles = 0;
    while (!done && cycles < 300) begin
      #1;
      if (cpu_if.req_fulfilled === 1'b1) begin
        done  = 1'b1;
        got_n = req_log.size() - start;
        check_eq("fetch_word", cpu_if.req_loaded_word, (addr & ~32'h3) ^ salt);
        check_eq("fetch_req_count", got_n, exp_n);
        check_eq("fulfil_outside_fill", 32'(mem_if.req_valid), 32'd0);
        if (hit) check_eq("hit_same_cycle", cycles, 0);
      end else begin
        if (flush_at > 0 && !flushed && (req_log.size() - start) >= flush_at) begin
          flush   = 1'b1;
          flushed = 1'b1;
        end else begin
          flush = 1'b0;
        end
        @(negedge clk);
        cycles++;
      end
    end
    flush = 1'b0;
    check_eq("fetch_done", 32'(done), 32'd1);
    got_n = req_log.size() - start;
    for (int k = 0; k < got_n && k < exp_n; k++)
      check_eq("fill_addr", req_log[start + k], (line << 4) + 32'(4 * (k % W)));
    @(negedge clk);
    cpu_if.req_valid = 1'b0;
    if (flush_at > 0) model_clear();
    if (!hit) begin
      model_valid[idx] = 1'b1;
      model_line[idx]  = line;
    end
  endtask

  task automatic reset_mid_fill(input logic [31:0] addr);
    int start, cycles;
    fixed_delay = 4;
    start  = req_log.size();
    cycles = 0;
    @(negedge clk);
    #1;
    cpu_if.req_valid   = 1'b1;
    cpu_if.req_address = addr;
    while ((req_log.size() - start) < 3 && cycles < 200) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    check_eq("rst_third_req", req_log.size() - start, 3);
    reset = 1'b1;
    cpu_if.req_valid = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    check_eq("rst_mem_valid", 32'(mem_if.req_valid), 32'd0);
    check_eq("rst_mem_addr", mem_if.req_address, 32'd0);
    check_eq("rst_cpu_fulfil", 32'(cpu_if.req_fulfilled), 32'd0);
    model_clear();
    start = req_log.size();
    repeat (12) @(negedge clk);
    check_eq("rst_late_fulfil_ignored", req_log.size() - start, 0);
    fixed_delay = 1;
    fetch(addr, 0);
  endtask

  initial begin
    cpu_if.req_valid   = 1'b0;
    cpu_if.req_address = '0;
    fixed_delay = 1;
    salt = '0;
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_mem_valid", 32'(mem_if.req_valid), 32'd0);
    check_eq("reset_mem_addr", mem_if.req_address, 32'd0);
    check_eq("reset_cpu_fulfil", 32'(cpu_if.req_fulfilled), 32'd0);
    reset = 1'b0;

    fetch(32'h40, 0);
    fetch(32'h48, 0);
    fetch(32'h140, 0);
    fetch(32'h40, 0);
    do_flush();
    fetch(32'h40, 0);
    fetch(32'h240, 2);
    fetch(32'h244, 0);
    reset_mid_fill(32'h80);

    do_flush();
    salt = 32'h5A5A_0000;
    fixed_delay = -1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 49) == 0) do_flush();
      fetch($urandom_range(0, 255) * 4, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
